demux_flit_route_ctrl: RTL and testbench



---
 rtl/demux_flit_route_ctrl.sv | 136 +++++++++++++
 tb/tb_demux_flit_route_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_flit_route_ctrl.sv
// Wormhole route controller for a 1x4 flit demux: head decode, path lock and per-output credits.
// Define ROUTE_CTRL_STATS_EN to add per-port completed-packet counters on pktCount.
module demux_flit_route_ctrl #(
    parameter int flitWidth   = 14,
    parameter int creditDepth = 4,
    parameter int creditWidth = 3
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [flitWidth-1:0] inputFlit,
    output logic [1:0]           select,
    output logic [flitWidth-1:0] outFlit,
    output logic [3:0]           outValid,
    input  logic [3:0]           creditReturn,
    output logic                 busy
`ifdef ROUTE_CTRL_STATS_EN
    ,
    output logic [63:0]          pktCount
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;
    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    localparam logic [creditWidth-1:0] CreditFull = creditWidth'(creditDepth);
    localparam logic [creditWidth-1:0] CreditOne  = creditWidth'(1);

    state_t                 state, state_next;
    logic [1:0]             locked_port, locked_port_next;
    logic [creditWidth-1:0] credit [4];
    flit_type_t             flit_type;
    logic [1:0]             dest;
    logic [1:0]             xfer_port;
    logic                   ready;
    logic                   xfer;
    logic [3:0]             take;

    assign flit_type = flit_type_t'(inputFlit[flitWidth-1 -: 2]);
    assign dest      = inputFlit[1:0];

    // NOTE: every signal written here gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next       = state;
        locked_port_next = locked_port;
        xfer_port        = dest;
        ready            = 1'b0;
        case (state)
            IDLE: begin
                // Body/tail flits here are a protocol error and are simply left unconsumed.
                ready = inValid && (flit_type == HEAD || flit_type == SINGLE)
                        && (credit[dest] != '0);
                if (ready && flit_type == HEAD) begin
                    state_next       = LOCKED;
                    locked_port_next = dest;
                end
            end
            LOCKED: begin
                // Any non-tail flit, including a stray head or single, continues the locked packet.
                xfer_port = locked_port;
                ready     = inValid && (credit[locked_port] != '0);
                if (ready && flit_type == TAIL) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign inReady = ready;
    assign xfer    = ready;
    assign take    = xfer ? (4'b0001 << xfer_port) : 4'b0000;
    assign busy    = (state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            locked_port <= '0;
            select      <= '0;
            outFlit     <= '0;
            outValid    <= '0;
        end else begin
            state       <= state_next;
            locked_port <= locked_port_next;
            outValid    <= take;
            if (xfer) begin
                select  <= xfer_port;
                outFlit <= inputFlit;
            end
        end
    end

    // NOTE: the credit array is plain flops, not RAM, so every entry is reset to a full window.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) credit[i] <= CreditFull;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (take[i] && !creditReturn[i]) begin
                    credit[i] <= credit[i] - CreditOne;
                end else if (!take[i] && creditReturn[i] && credit[i] != CreditFull) begin
                    credit[i] <= credit[i] + CreditOne;
                end
            end
        end
    end

`ifdef ROUTE_CTRL_STATS_EN
    logic [15:0] pkt_cnt [4];
    logic        pkt_end;

    // A packet completes on a single in IDLE or a tail in LOCKED.
    assign pkt_end = (state == IDLE && flit_type == SINGLE) || (state == LOCKED && flit_type == TAIL);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 4; i++) pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (take[i] && pkt_end && pkt_cnt[i] != 16'hFFFF) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign pktCount = {pkt_cnt[3], pkt_cnt[2], pkt_cnt[1], pkt_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_flit_route_ctrl.sv
// Directed, table-driven bench for demux_flit_route_ctrl plus hand-written credit and reset sequences.
module tb_demux_flit_route_ctrl;
    localparam int FW = 14;
    localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [FW-1:0] inputFlit = '0;
    logic [1:0]    select;
    logic [FW-1:0] outFlit;
    logic [3:0]    outValid;
    logic [3:0]    creditReturn = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    demux_flit_route_ctrl #(.flitWidth(FW), .creditDepth(4), .creditWidth(3)) dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .inputFlit(inputFlit),
        .select(select), .outFlit(outFlit), .outValid(outValid),
        .creditReturn(creditReturn), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [FW-1:0] flit;
        logic [3:0]    cr;
        logic          rdy;
        logic [3:0]    ov;
        logic [1:0]    sel;
        logic [FW-1:0] of;
        logic          bsy;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [9:0] p, input logic [1:0] d);
        return {t, p, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // inReady is checked mid-cycle after driving; registered outputs 1 ns after the edge.
    task automatic cyc(input string name, input logic v, input logic [FW-1:0] f, input logic [3:0] cr,
                       input logic rdy, input logic [3:0] ov, input logic [1:0] sel,
                       input logic [FW-1:0] of, input logic bsy);
        @(negedge clk);
        inValid = v;
        inputFlit = f;
        creditReturn = cr;
        #1;
        check({name, ".inReady"}, 32'(inReady), 32'(rdy));
        @(posedge clk);
        #1;
        check({name, ".outValid"}, 32'(outValid), 32'(ov));
        check({name, ".select"}, 32'(select), 32'(sel));
        check({name, ".outFlit"}, 32'(outFlit), 32'(of));
        check({name, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic check_zero(input string name);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".outValid"}, 32'(outValid), 32'd0);
        check({name, ".select"}, 32'(select), 32'd0);
        check({name, ".outFlit"}, 32'(outFlit), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        inValid = 1'b0;
        creditReturn = '0;
        rstN = 1'b0;
        #2;
        check_zero(name);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] fA, fB, fC, fD, fE, fF, fG, fH, fI, fJ, fK, fL, fM, fN, fO, fP;
        logic [FW-1:0] h, b1, b2, b3, b4, t, s, bd, hd;

        fA = mk(T_SINGLE, 10'h155, 2'd2); fB = mk(T_HEAD, 10'h0A1, 2'd1);
        fC = mk(T_BODY, 10'h0A2, 2'd3);   fD = mk(T_BODY, 10'h0A3, 2'd0);
        fE = mk(T_TAIL, 10'h0A4, 2'd2);   fF = mk(T_SINGLE, 10'h0B5, 2'd1);
        fG = mk(T_BODY, 10'h0C6, 2'd0);   fH = mk(T_TAIL, 10'h0C7, 2'd0);
        fI = mk(T_SINGLE, 10'h0D1, 2'd2); fJ = mk(T_SINGLE, 10'h0D2, 2'd2);
        fK = mk(T_SINGLE, 10'h0D3, 2'd2); fL = mk(T_SINGLE, 10'h0D4, 2'd2);
        fM = mk(T_HEAD, 10'h0E1, 2'd0);   fN = mk(T_HEAD, 10'h0E2, 2'd3);
        fO = mk(T_SINGLE, 10'h0E3, 2'd2); fP = mk(T_TAIL, 10'h0E4, 2'd1);

        //            v     flit cr       rdy   ov       sel   outFlit bsy
        vecs[0]  = '{1'b1, fA, 4'b0000, 1'b1, 4'b0100, 2'd2, fA, 1'b0}; // single to port 2
        vecs[1]  = '{1'b0, fA, 4'b0000, 1'b0, 4'b0000, 2'd2, fA, 1'b0}; // idle: outputs hold
        vecs[2]  = '{1'b1, fB, 4'b0000, 1'b1, 4'b0010, 2'd1, fB, 1'b1}; // head to port 1
        vecs[3]  = '{1'b1, fC, 4'b0000, 1'b1, 4'b0010, 2'd1, fC, 1'b1}; // body, dest bits ignored
        vecs[4]  = '{1'b1, fD, 4'b0000, 1'b1, 4'b0010, 2'd1, fD, 1'b1};
        vecs[5]  = '{1'b1, fE, 4'b0000, 1'b1, 4'b0010, 2'd1, fE, 1'b0}; // tail unlocks
        vecs[6]  = '{1'b1, fF, 4'b0000, 1'b0, 4'b0000, 2'd1, fE, 1'b0}; // port 1 out of credit
        vecs[7]  = '{1'b1, fF, 4'b0010, 1'b0, 4'b0000, 2'd1, fE, 1'b0}; // return lands next cycle
        vecs[8]  = '{1'b1, fF, 4'b0000, 1'b1, 4'b0010, 2'd1, fF, 1'b0};
        vecs[9]  = '{1'b1, fG, 4'b0000, 1'b0, 4'b0000, 2'd1, fF, 1'b0}; // body in IDLE refused
        vecs[10] = '{1'b1, fH, 4'b0000, 1'b0, 4'b0000, 2'd1, fF, 1'b0}; // tail in IDLE refused
        vecs[11] = '{1'b1, fI, 4'b0000, 1'b1, 4'b0100, 2'd2, fI, 1'b0}; // port 2 has 3 left
        vecs[12] = '{1'b1, fJ, 4'b0000, 1'b1, 4'b0100, 2'd2, fJ, 1'b0};
        vecs[13] = '{1'b1, fK, 4'b0000, 1'b1, 4'b0100, 2'd2, fK, 1'b0};
        vecs[14] = '{1'b1, fL, 4'b0000, 1'b0, 4'b0000, 2'd2, fK, 1'b0};
        vecs[15] = '{1'b1, fM, 4'b0000, 1'b1, 4'b0001, 2'd0, fM, 1'b1}; // head to port 0
        vecs[16] = '{1'b1, fN, 4'b0000, 1'b1, 4'b0001, 2'd0, fN, 1'b1}; // head while locked = body
        vecs[17] = '{1'b1, fO, 4'b0000, 1'b1, 4'b0001, 2'd0, fO, 1'b1}; // single while locked = body
        vecs[18] = '{1'b1, fP, 4'b0000, 1'b1, 4'b0001, 2'd0, fP, 1'b0};

        do_reset("rst0");
        for (int i = 0; i < 19; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].v, vecs[i].flit, vecs[i].cr, vecs[i].rdy,
                vecs[i].ov, vecs[i].sel, vecs[i].of, vecs[i].bsy);
        end

        // Six-flit packet to port 3 against a four-credit window.
        do_reset("rstA");
        h  = mk(T_HEAD, 10'h301, 2'd3); b1 = mk(T_BODY, 10'h302, 2'd0);
        b2 = mk(T_BODY, 10'h303, 2'd1); b3 = mk(T_BODY, 10'h304, 2'd2);
        b4 = mk(T_BODY, 10'h305, 2'd3); t  = mk(T_TAIL, 10'h306, 2'd0);
        cyc("A.h",  1'b1, h,  4'b0000, 1'b1, 4'b1000, 2'd3, h,  1'b1);
        cyc("A.b1", 1'b1, b1, 4'b0000, 1'b1, 4'b1000, 2'd3, b1, 1'b1);
        cyc("A.b2", 1'b1, b2, 4'b0000, 1'b1, 4'b1000, 2'd3, b2, 1'b1);
        cyc("A.b3", 1'b1, b3, 4'b0000, 1'b1, 4'b1000, 2'd3, b3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc($sformatf("A.stall%0d", i), 1'b1, b4, 4'b0000, 1'b0, 4'b0000, 2'd3, b3, 1'b1);
        end
        cyc("A.ret1", 1'b1, b4, 4'b1000, 1'b0, 4'b0000, 2'd3, b3, 1'b1);
        cyc("A.b4",   1'b1, b4, 4'b0000, 1'b1, 4'b1000, 2'd3, b4, 1'b1);
        cyc("A.ret2", 1'b1, t,  4'b1000, 1'b0, 4'b0000, 2'd3, b4, 1'b1);
        cyc("A.t",    1'b1, t,  4'b0000, 1'b1, 4'b1000, 2'd3, t,  1'b0);

        // Saturation on port 2, then simultaneous return and transfer on port 0.
        do_reset("rstB");
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("B.sat%0d", i), 1'b0, '0, 4'b0100, 1'b0, 4'b0000, 2'd0, '0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            s = mk(T_SINGLE, 10'(12'h200 + i), 2'd2);
            cyc($sformatf("B.p2_%0d", i), 1'b1, s, 4'b0000, 1'b1, 4'b0100, 2'd2, s, 1'b0);
        end
        cyc("B.p2_blk", 1'b1, mk(T_SINGLE, 10'h2FF, 2'd2), 4'b0000, 1'b0, 4'b0000, 2'd2, s, 1'b0);
        for (int i = 0; i < 2; i++) begin
            s = mk(T_SINGLE, 10'(12'h400 + i), 2'd0);
            cyc($sformatf("B.p0_%0d", i), 1'b1, s, 4'b0000, 1'b1, 4'b0001, 2'd0, s, 1'b0);
        end
        s = mk(T_SINGLE, 10'h410, 2'd0);
        cyc("B.same", 1'b1, s, 4'b0001, 1'b1, 4'b0001, 2'd0, s, 1'b0);
        for (int i = 0; i < 2; i++) begin
            s = mk(T_SINGLE, 10'(12'h420 + i), 2'd0);
            cyc($sformatf("B.left%0d", i), 1'b1, s, 4'b0000, 1'b1, 4'b0001, 2'd0, s, 1'b0);
        end
        cyc("B.p0_blk", 1'b1, mk(T_SINGLE, 10'h42F, 2'd0), 4'b0000, 1'b0, 4'b0000, 2'd0, s, 1'b0);

        // Body flit in IDLE is never consumed; reset then clears everything.
        bd = mk(T_BODY, 10'h501, 2'd1);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("C.hold%0d", i), 1'b1, bd, 4'b0000, 1'b0, 4'b0000, 2'd0, s, 1'b0);
        end
        do_reset("rstC");

        // Asynchronous reset in the middle of a packet to port 1.
        hd = mk(T_HEAD, 10'h601, 2'd1);
        b1 = mk(T_BODY, 10'h602, 2'd0);
        b2 = mk(T_BODY, 10'h603, 2'd0);
        cyc("D.h",  1'b1, hd, 4'b0000, 1'b1, 4'b0010, 2'd1, hd, 1'b1);
        cyc("D.b1", 1'b1, b1, 4'b0000, 1'b1, 4'b0010, 2'd1, b1, 1'b1);
        cyc("D.b2", 1'b1, b2, 4'b0000, 1'b1, 4'b0010, 2'd1, b2, 1'b1);
        #2;
        rstN = 1'b0;
        inValid = 1'b0;
        #1;
        check_zero("D.async");
        check("D.async.inReady", 32'(inReady), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        h = mk(T_HEAD, 10'h701, 2'd0);
        t = mk(T_TAIL, 10'h702, 2'd3);
        cyc("D.h0", 1'b1, h, 4'b0000, 1'b1, 4'b0001, 2'd0, h, 1'b1);
        cyc("D.t0", 1'b1, t, 4'b0000, 1'b1, 4'b0001, 2'd0, t, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s = mk(T_SINGLE, 10'(12'h710 + i), 2'd1);
            cyc($sformatf("D.p1_%0d", i), 1'b1, s, 4'b0000, 1'b1, 4'b0010, 2'd1, s, 1'b0);
        end
        cyc("D.p1_blk", 1'b1, mk(T_SINGLE, 10'h71F, 2'd1), 4'b0000, 1'b0, 4'b0000, 2'd1, s, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
